// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Button conditioning (sync + debounce + press detect) and the
//            IDLE/RUN/PAUSE/LAP sequencer for a 4-digit BCD stopwatch.
//            Generates the hundredths tick, the counter clear pulse and the
//            display-hold level.
// Options  : STOPWATCH_CTRL_LAP_CNT_EN adds the saturating lap_cnt_o output.
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_DIV        = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop_i,
  input  logic       lap_reset_i,
  output logic       tick_o,
  output logic       clear_o,
  output logic       hold_o,
  output logic       running_o,
  output logic [1:0] state_o
`ifdef STOPWATCH_CTRL_LAP_CNT_EN
  ,
  output logic [3:0] lap_cnt_o
`endif
);

  localparam int c_DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int c_PS_W = $clog2(TICK_DIV);
  localparam logic [c_DB_W-1:0] c_DB_LAST = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_PS_W-1:0] c_PS_LAST = c_PS_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_LAP   = 2'd3
  } state_t;

  // Bit 0 = start/stop, bit 1 = lap/reset
  logic [1:0] w_raw;
  logic [1:0] w_press;

  assign w_raw = {lap_reset_i, start_stop_i};

  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic [1:0]        r_sync;
    logic [c_DB_W-1:0] r_cnt;
    logic              r_deb;
    logic              r_deb_q;

    // Synchronise the raw button, then only follow a level that stayed put long enough
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_sync  <= 2'b00;
        r_cnt   <= '0;
        r_deb   <= 1'b0;
        r_deb_q <= 1'b0;
      end else begin
        r_sync  <= {r_sync[0], w_raw[gi]};
        r_deb_q <= r_deb;
        if (r_sync[1] != r_deb) begin
          if (r_cnt == c_DB_LAST) begin
            r_deb <= ~r_deb;
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + c_DB_W'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    // One-cycle event on the rising edge of the debounced level only
    assign w_press[gi] = r_deb & ~r_deb_q;
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_clear_nxt;
  logic                r_clear;
  logic [c_PS_W-1:0]   r_presc;
  logic                w_running;

  // Sequencer state register and registered clear pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_clear <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_clear <= w_clear_nxt;
    end
  end

  // Next-state decode; start/stop has priority and a coincident lap event is dropped
  always_comb begin
    w_state_nxt = r_state;
    w_clear_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_press[0])      w_state_nxt = S_RUN;
        else if (w_press[1]) w_clear_nxt = 1'b1;
      end
      S_RUN: begin
        if (w_press[0])      w_state_nxt = S_PAUSE;
        else if (w_press[1]) w_state_nxt = S_LAP;
      end
      S_LAP: begin
        if (w_press[0])      w_state_nxt = S_PAUSE;
        else if (w_press[1]) w_state_nxt = S_RUN;
      end
      S_PAUSE: begin
        if (w_press[0]) begin
          w_state_nxt = S_RUN;
        end else if (w_press[1]) begin
          w_state_nxt = S_IDLE;
          w_clear_nxt = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_running = (r_state == S_RUN) || (r_state == S_LAP);

  // Prescaler runs while timing, holds when stopped so resume keeps the partial interval
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_presc <= '0;
    end else if (w_clear_nxt) begin
      r_presc <= '0;
    end else if (w_running) begin
      if (r_presc == c_PS_LAST) r_presc <= '0;
      else                      r_presc <= r_presc + c_PS_W'(1);
    end
  end

  assign state_o   = r_state;
  assign running_o = w_running;
  assign hold_o    = (r_state == S_LAP);
  assign clear_o   = r_clear;
  assign tick_o    = w_running && (r_presc == c_PS_LAST);

`ifdef STOPWATCH_CTRL_LAP_CNT_EN
  logic [3:0] r_lap_cnt;

  // Count entries into LAP, saturating; cleared alongside the digit counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lap_cnt <= 4'd0;
    end else if (w_clear_nxt) begin
      r_lap_cnt <= 4'd0;
    end else if ((w_state_nxt == S_LAP) && (r_state != S_LAP) && (r_lap_cnt != 4'd15)) begin
      r_lap_cnt <= r_lap_cnt + 4'd1;
    end
  end

  assign lap_cnt_o = r_lap_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Scoreboard bench for stopwatch_ctrl. A behavioural model predicts
//            the outputs of every cycle into a queue; a monitor pops and
//            compares on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int D  = 4;
  localparam int TD = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_stop_i = 1'b0;
  logic       lap_reset_i = 1'b0;
  logic       tick_o, clear_o, hold_o, running_o;
  logic [1:0] state_o;
`ifdef STOPWATCH_CTRL_LAP_CNT_EN
  logic [3:0] lap_cnt_o;
`endif

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_DIV(TD)) dut (
    .clk          (clk),
    .reset        (reset),
    .start_stop_i (start_stop_i),
    .lap_reset_i  (lap_reset_i),
    .tick_o       (tick_o),
    .clear_o      (clear_o),
    .hold_o       (hold_o),
    .running_o    (running_o),
    .state_o      (state_o)
`ifdef STOPWATCH_CTRL_LAP_CNT_EN
    ,
    .lap_cnt_o    (lap_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0] st;
    logic       clr;
    logic       hold;
    logic       run;
    logic       tick;
    logic [3:0] lc;
  } exp_t;

  exp_t sb[$];

  // Mode transition tables indexed by mode: 0 idle, 1 run, 2 pause, 3 lap
  int ss_next  [4] = '{1, 2, 1, 2};
  int lap_next [4] = '{0, 3, 0, 1};
  int lap_clr  [4] = '{1, 0, 1, 0};

  // Model state
  int m_mode = 0, m_phase = 0, m_lc = 0;
  bit m_clear = 0;
  bit deb  [2] = '{0, 0};
  bit prev [2] = '{0, 0};
  bit hist_ss[$];
  bit hist_lp[$];

  // Raw sample taken 'age' edges ago (0 = this edge); before history exists it reads 0
  function automatic bit samp(input int b, input int age);
    if (b == 0) return (age < hist_ss.size()) ? hist_ss[hist_ss.size()-1-age] : 1'b0;
    else        return (age < hist_lp.size()) ? hist_lp[hist_lp.size()-1-age] : 1'b0;
  endfunction

  // A debounced level flips once the synchronised input (2 edges late) has
  // sat at the opposite level for D consecutive samples.
  function automatic bit flips(input int b);
    for (int a = 2; a <= D + 1; a++)
      if (samp(b, a) == deb[b]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    if (reset) begin
      m_mode = 0; m_phase = 0; m_lc = 0; m_clear = 0;
      deb = '{0, 0}; prev = '{0, 0};
      hist_ss.delete(); hist_lp.delete();
    end else begin
      bit ev_ss, ev_lp;
      int old;
      ev_ss = deb[0] && !prev[0];
      ev_lp = deb[1] && !prev[1];
      old = m_mode;
      m_clear = 0;
      if (ev_ss) m_mode = ss_next[old];
      else if (ev_lp) begin
        m_mode  = lap_next[old];
        m_clear = lap_clr[old] != 0;
      end
      if (m_clear) m_phase = 0;
      else if (old == 1 || old == 3) m_phase = (m_phase + 1) % TD;
      if (m_clear) m_lc = 0;
      else if (m_mode == 3 && old != 3 && m_lc < 15) m_lc++;
      prev = deb;
      hist_ss.push_back(start_stop_i);
      hist_lp.push_back(lap_reset_i);
      if (hist_ss.size() > D + 2) void'(hist_ss.pop_front());
      if (hist_lp.size() > D + 2) void'(hist_lp.pop_front());
      for (int b = 0; b < 2; b++)
        if (flips(b)) deb[b] = !deb[b];
    end
    e.st   = 2'(m_mode);
    e.clr  = m_clear;
    e.hold = (m_mode == 3);
    e.run  = (m_mode == 1 || m_mode == 3);
    e.tick = e.run && (m_phase == TD - 1);
    e.lc   = 4'(m_lc);
    sb.push_back(e);
  end

  // Monitor: compare one predicted cycle against the DUT on each falling edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("state_o",   int'(state_o),   int'(e.st));
      chk("clear_o",   int'(clear_o),   int'(e.clr));
      chk("hold_o",    int'(hold_o),    int'(e.hold));
      chk("running_o", int'(running_o), int'(e.run));
      chk("tick_o",    int'(tick_o),    int'(e.tick));
`ifdef STOPWATCH_CTRL_LAP_CNT_EN
      chk("lap_cnt_o", int'(lap_cnt_o), int'(e.lc));
`endif
    end
  end

  task automatic drive(input bit ss, input bit lp, input int n);
    @(negedge clk);
    start_stop_i = ss;
    lap_reset_i  = lp;
    repeat (n - 1) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;

    drive(1, 0, 3);  drive(0, 0, 15);   // short glitch: ignored
    drive(1, 0, 12); drive(0, 0, 35);   // held press: one event, IDLE -> RUN
    drive(0, 1, 6);  drive(0, 0, 25);   // RUN -> LAP
    drive(0, 1, 6);  drive(0, 0, 14);   // LAP -> RUN
    drive(1, 0, 6);  drive(0, 0, 20);   // RUN -> PAUSE
    drive(1, 0, 6);  drive(0, 0, 20);   // PAUSE -> RUN, partial interval resumes
    drive(1, 0, 6);  drive(0, 0, 10);   // RUN -> PAUSE
    drive(0, 1, 6);  drive(0, 0, 10);   // PAUSE -> IDLE with clear
    drive(0, 1, 6);  drive(0, 0, 10);   // IDLE lap: clear only
    drive(1, 0, 6);  drive(0, 0, 15);   // IDLE -> RUN
    drive(1, 1, 6);  drive(0, 0, 10);   // simultaneous: start/stop wins -> PAUSE
    drive(1, 0, 6);  drive(0, 0, 17);   // back to RUN

    // Asynchronous reset in the middle of a cycle while running
    @(negedge clk);
    chk("pre_reset_running", int'(running_o), (m_mode == 1 || m_mode == 3) ? 1 : 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_state",   int'(state_o),   0);
    chk("async_rst_running", int'(running_o), 0);
    chk("async_rst_hold",    int'(hold_o),    0);
    chk("async_rst_tick",    int'(tick_o),    0);
    chk("async_rst_clear",   int'(clear_o),   0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 9)));
      drive(0, 0, int'($urandom_range(1, 8)));
    end
    drive(0, 0, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
